mux_4_rr_arbiter: RTL and testbench
===================================

// Module: mux_4_rr_arbiter
//
// PURPOSE
// - Round-robin arbiter and sequencer for the 4:1 mux (mux_4). Four requesters share the mux's single-bit output y.
// - Grants one requester at a time and drives the mux select c[1:0] to the granted index.
// - Registers the selected y into y_q for downstream logic.
// - Sits directly in front of mux_4: the c output connects to mux_4.c, and the y input connects to mux_4.y.
//
// PARAMETERS
// - HOLD_MAX  8  max consecutive GRANT cycles when another request is pending (timeout build only); legal range 2..15.
// - CNT_W     4  width of the hold counter; must satisfy 2**CNT_W > HOLD_MAX.
//
// PORTS
// - clk      in   1  rising-edge clock
// - rst      in   1  asynchronous, active-high reset
// - req      in   4  request per source; req[0] owns x1 ... req[3] owns x4
// - y        in   1  output of mux_4
// - c        out  2  mux select; equals the granted index while valid=1
// - grant    out  4  one-hot grant, all-zero when idle
// - valid    out  1  high while in GRANT
// - y_q      out  1  y registered on every clk edge where valid=1; holds its value otherwise
//
// BEHAVIOUR
// - Reset (asynchronous, may occur mid-grant): state=IDLE, grant=4'b0000, c=2'b00, valid=0, y_q=0, ptr=2'b00, cnt=0.
// - ptr (2-bit rotating pointer): scan order is ptr, ptr+1, ptr+2, ptr+3, all mod 4.
// - IDLE:
//   - If req != 0, pick the first set bit k in scan order.
//   - Next edge: state=GRANT, grant=1<<k, c=k, valid=1, ptr=k+1 mod 4 (wraps 3->0), cnt=0.
//   - If req == 0, stay in IDLE with outputs at their idle values; c holds its last value.
// - GRANT:
//   - While req[c]=1: hold grant, c and valid.
//   - cnt increments each cycle, saturating at HOLD_MAX-1.
// - Release (any of the following), next edge: state=IDLE, grant=0, valid=0, c unchanged.
//   - req[c]=0.
//   - Timeout: see CONFIGURATION.
// - Latency:
//   - req to grant: 1 cycle from IDLE.
//   - Release to grant clear: 1 cycle.
//   - Release to next grant: 2 cycles (one mandatory IDLE cycle, so c never changes while valid=1).
// - Simultaneous events:
//   - Release and timeout in the same cycle count as a single release.
//   - Requests that arrive in the cycle grant is issued wait for the next IDLE scan.
// - Fairness: a continuously asserted requester waits at most 3 grants before it is served.
// - The grant register is one-hot or zero at all times. c is always in 0..3, so there is no out-of-range select.
//
// CONFIGURATION
// - MUX4_ARB_TIMEOUT_EN defined:
//   - In GRANT, when cnt == HOLD_MAX-1 and (req & ~grant) != 0, force release on the next edge (same effect as req drop).
//   - If no other request is pending at the limit, the grant persists; cnt stays saturated until a release.
// - MUX4_ARB_TIMEOUT_EN undefined:
//   - cnt logic is not built; the grant is held until req[c] drops. HOLD_MAX and CNT_W are ignored.
//
// TESTING
// - Apply and release reset. Then req=4'b0100 -> next edge grant=0100, c=2'b10, valid=1; with y=1, y_q=1 one edge later.
// - With ptr=0, apply req=4'b1111 and drop each granted req after 2 cycles.
//   - Required grant order: 0001, 0010, 0100, 1000, 0001 (wrap).
//   - Exactly one IDLE cycle separates each grant.
// - Timeout build, HOLD_MAX=8:
//   - req[0] held high and req[2] asserted -> grant 0001 for 8 cycles, then IDLE, then 0100.
//   - Non-timeout build with the same stimulus: grant 0001 persists indefinitely.
// - Timeout build: only req[1] held high for 20 cycles -> grant=0010 stays continuously; valid never drops.
// - Assert rst mid-GRANT (grant=1000) -> grant, valid and c clear immediately without waiting for clk.
//   - After release, req=4'b1001 -> grant=0001 (ptr reset to 0).
// - Drop req[c] in the same cycle the timeout fires -> a single release, one IDLE cycle, then the next requester in scan order is granted.

Source files
------------

// File: rtl/mux_4_rr_arbiter.sv
// Round-robin arbiter and sequencer for the 4:1 mux: grants one of four requesters, drives the mux select and registers the mux output.
// Optional hold-timeout is built when MUX4_ARB_TIMEOUT_EN is defined.
module mux_4_rr_arbiter #(
    parameter int HOLD_MAX = 8,
    parameter int CNT_W    = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req,
    input  logic       y,
    output logic [1:0] c,
    output logic [3:0] grant,
    output logic       valid,
    output logic       y_q
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t     state_q;
    logic [3:0] grant_q;
    logic [1:0] c_q;
    logic       valid_q;
    logic       y_q_q;
    logic [1:0] ptr_q;

    logic [1:0] idx_d;
    logic [1:0] cand_d;
    logic       any_req_d;
    logic       release_d;

    if (HOLD_MAX < 2 || HOLD_MAX > 15 || (2 ** CNT_W) <= HOLD_MAX) begin : g_bad_cfg
        $error("mux_4_rr_arbiter: HOLD_MAX must be 2..15 and fit in CNT_W bits");
    end

    // Scan from ptr upward; walking offsets high-to-low lets the lowest offset win.
    always_comb begin
        idx_d     = ptr_q;
        cand_d    = ptr_q;
        any_req_d = 1'b0;
        for (int i = 3; i >= 0; i--) begin
            cand_d = ptr_q + 2'(i);
            if (req[cand_d]) begin
                idx_d     = cand_d;
                any_req_d = 1'b1;
            end
        end
    end

`ifdef MUX4_ARB_TIMEOUT_EN
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(HOLD_MAX - 1);

    logic [CNT_W-1:0] cnt_q;
    logic             timeout_d;

    assign timeout_d = (cnt_q == CNT_MAX) && ((req & ~grant_q) != 4'b0000);

    always_comb begin
        release_d = ~req[c_q] | timeout_d;
    end

    // Hold counter restarts on every new grant and saturates at the limit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (state_q == IDLE) begin
            cnt_q <= '0;
        end else if (cnt_q != CNT_MAX) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end
`else
    always_comb begin
        release_d = ~req[c_q];
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            grant_q <= 4'b0000;
            c_q     <= 2'b00;
            valid_q <= 1'b0;
            y_q_q   <= 1'b0;
            ptr_q   <= 2'b00;
        end else begin
            if (valid_q) begin
                y_q_q <= y;
            end
            case (state_q)
                IDLE: begin
                    if (any_req_d) begin
                        state_q <= GRANT;
                        grant_q <= 4'b0001 << idx_d;
                        c_q     <= idx_d;
                        valid_q <= 1'b1;
                        ptr_q   <= idx_d + 2'd1;
                    end
                end
                GRANT: begin
                    // c stays put on release so the select never moves while valid is high.
                    if (release_d) begin
                        state_q <= IDLE;
                        grant_q <= 4'b0000;
                        valid_q <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    grant_q <= 4'b0000;
                    valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign c     = c_q;
    assign grant = grant_q;
    assign valid = valid_q;
    assign y_q   = y_q_q;

endmodule

// File: tb/tb_mux_4_rr_arbiter.sv
// Directed testbench for mux_4_rr_arbiter; inputs change and outputs are sampled on the falling clock edge.
module tb_mux_4_rr_arbiter;

    logic       clk;
    logic       rst;
    logic [3:0] req;
    logic       y;
    logic [1:0] c;
    logic [3:0] grant;
    logic       valid;
    logic       y_q;

    int errors;
    int checks;

    mux_4_rr_arbiter #(.HOLD_MAX(8), .CNT_W(4)) dut (
        .clk   (clk),
        .rst   (rst),
        .req   (req),
        .y     (y),
        .c     (c),
        .grant (grant),
        .valid (valid),
        .y_q   (y_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic do_reset();
        req = 4'b0000;
        y   = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        req = 4'b0000;
        y   = 1'b1;
        rst = 1'b1;
        @(negedge clk);
        checks++; if (grant !== 4'b0000) begin errors++; $display("FAIL reset_grant got=%b exp=0000", grant); end
        checks++; if (c !== 2'b00) begin errors++; $display("FAIL reset_c got=%b exp=00", c); end
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", valid); end
        checks++; if (y_q !== 1'b0) begin errors++; $display("FAIL reset_y_q got=%b exp=0", y_q); end
        rst = 1'b0;
        y   = 1'b0;
    endtask

    task automatic test_single_grant();
        do_reset();
        req = 4'b0100;
        y   = 1'b1;
        @(negedge clk);
        checks++; if (grant !== 4'b0100) begin errors++; $display("FAIL single_grant got=%b exp=0100", grant); end
        checks++; if (c !== 2'b10) begin errors++; $display("FAIL single_c got=%b exp=10", c); end
        checks++; if (valid !== 1'b1) begin errors++; $display("FAIL single_valid got=%b exp=1", valid); end
        checks++; if (y_q !== 1'b0) begin errors++; $display("FAIL single_y_q_early got=%b exp=0", y_q); end
        @(negedge clk);
        checks++; if (y_q !== 1'b1) begin errors++; $display("FAIL single_y_q got=%b exp=1", y_q); end
        req = 4'b0000;
        @(negedge clk);
        checks++; if (grant !== 4'b0000) begin errors++; $display("FAIL single_release_grant got=%b exp=0000", grant); end
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL single_release_valid got=%b exp=0", valid); end
        checks++; if (c !== 2'b10) begin errors++; $display("FAIL single_release_c got=%b exp=10", c); end
        y = 1'b0;
        @(negedge clk);
        checks++; if (y_q !== 1'b1) begin errors++; $display("FAIL single_y_q_hold got=%b exp=1", y_q); end
        checks++; if (c !== 2'b10) begin errors++; $display("FAIL idle_c_hold got=%b exp=10", c); end
    endtask

    task automatic test_round_robin();
        logic [3:0] exp_g [5];
        logic [1:0] exp_c [5];
        exp_g = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        exp_c = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        do_reset();
        req = 4'b1111;
        for (int g = 0; g < 5; g++) begin
            @(negedge clk);
            checks++; if (grant !== exp_g[g]) begin errors++; $display("FAIL rr_grant[%0d] got=%b exp=%b", g, grant, exp_g[g]); end
            checks++; if (c !== exp_c[g]) begin errors++; $display("FAIL rr_c[%0d] got=%0d exp=%0d", g, c, exp_c[g]); end
            @(negedge clk);
            checks++; if (grant !== exp_g[g]) begin errors++; $display("FAIL rr_hold[%0d] got=%b exp=%b", g, grant, exp_g[g]); end
            req = 4'b1111 & ~exp_g[g];
            @(negedge clk);
            checks++; if (valid !== 1'b0 || grant !== 4'b0000) begin
                errors++; $display("FAIL rr_idle[%0d] got valid=%b grant=%b exp valid=0 grant=0000", g, valid, grant);
            end
            checks++; if (c !== exp_c[g]) begin errors++; $display("FAIL rr_idle_c[%0d] got=%0d exp=%0d", g, c, exp_c[g]); end
            req = 4'b1111;
        end
        req = 4'b0000;
    endtask

    task automatic test_contention_hold();
        do_reset();
        req = 4'b0101;
`ifdef MUX4_ARB_TIMEOUT_EN
        for (int i = 1; i <= 10; i++) begin
            logic [3:0] eg;
            @(negedge clk);
            eg = (i <= 8) ? 4'b0001 : ((i == 9) ? 4'b0000 : 4'b0100);
            checks++; if (grant !== eg) begin errors++; $display("FAIL timeout_grant[%0d] got=%b exp=%b", i, grant, eg); end
        end
`else
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            checks++; if (grant !== 4'b0001 || valid !== 1'b1) begin
                errors++; $display("FAIL hold_grant[%0d] got grant=%b valid=%b exp grant=0001 valid=1", i, grant, valid);
            end
        end
`endif
        req = 4'b0000;
        @(negedge clk);
    endtask

    task automatic test_single_holder();
        logic prev_y;
        prev_y = 1'b0;
        do_reset();
        req = 4'b0010;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            checks++; if (grant !== 4'b0010 || valid !== 1'b1) begin
                errors++; $display("FAIL holder[%0d] got grant=%b valid=%b exp grant=0010 valid=1", i, grant, valid);
            end
            if (i > 1) begin
                checks++; if (y_q !== prev_y) begin errors++; $display("FAIL holder_y_q[%0d] got=%b exp=%b", i, y_q, prev_y); end
            end
            y      = (i % 3 == 0);
            prev_y = y;
        end
        req = 4'b0000;
        @(negedge clk);
    endtask

    task automatic test_async_reset();
        do_reset();
        req = 4'b1000;
        @(negedge clk);
        checks++; if (grant !== 4'b1000 || c !== 2'b11) begin
            errors++; $display("FAIL areset_pre got grant=%b c=%b exp grant=1000 c=11", grant, c);
        end
        #2;
        rst = 1'b1;
        #1;
        checks++; if (grant !== 4'b0000) begin errors++; $display("FAIL areset_grant got=%b exp=0000", grant); end
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL areset_valid got=%b exp=0", valid); end
        checks++; if (c !== 2'b00) begin errors++; $display("FAIL areset_c got=%b exp=00", c); end
        @(negedge clk);
        rst = 1'b0;
        req = 4'b1001;
        @(negedge clk);
        checks++; if (grant !== 4'b0001 || c !== 2'b00) begin
            errors++; $display("FAIL areset_ptr got grant=%b c=%b exp grant=0001 c=00", grant, c);
        end
        req = 4'b0000;
        @(negedge clk);
    endtask

    task automatic test_release_with_timeout();
        do_reset();
        req = 4'b0101;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            checks++; if (grant !== 4'b0001) begin errors++; $display("FAIL drop_hold[%0d] got=%b exp=0001", i, grant); end
        end
        req = 4'b0100;
        @(negedge clk);
        checks++; if (grant !== 4'b0000 || valid !== 1'b0) begin
            errors++; $display("FAIL drop_idle got grant=%b valid=%b exp grant=0000 valid=0", grant, valid);
        end
        @(negedge clk);
        checks++; if (grant !== 4'b0100 || c !== 2'b10) begin
            errors++; $display("FAIL drop_next got grant=%b c=%b exp grant=0100 c=10", grant, c);
        end
        req = 4'b0000;
        @(negedge clk);
    endtask

    initial begin
        errors = 0;
        checks = 0;
        rst    = 1'b1;
        req    = 4'b0000;
        y      = 1'b0;
        test_reset();
        test_single_grant();
        test_round_robin();
        test_contention_hold();
        test_single_holder();
        test_async_reset();
        test_release_with_timeout();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
